dpram_sc_init: RTL and testbench

Single-clock simple dual-port RAM for the FIFO and buffer datapaths. It extends the basic dual-port RAM with per-byte write enables, a selectable read latency of 1 or 2 cycles, and a defined read-during-write policy. A post-reset init engine zero-fills the array, so read data is never undefined. Write and read requests are gated by the owner's full and empty flags, exactly as in the FIFO usage.

---
 rtl/dpram_pkg.sv | 28 ++
 rtl/dpram_init_ctrl.sv | 60 ++++++
 rtl/dpram_sc_init.sv | 136 +++++++++++++
 tb/tb_dpram_sc_init.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared types, latency bounds and byte-lane merge for dpram_sc_init
package dpram_pkg;

  typedef enum logic {ST_INIT, ST_READY} dpram_state_e;

  localparam int RdLatencyMin = 1;
  localparam int RdLatencyMax = 2;

  // Widest word be_merge handles; callers zero-extend into it and cast the result back down.
  localparam int MergeMaxW = 256;

  function automatic logic [MergeMaxW-1:0] be_merge(
    input logic [MergeMaxW-1:0] old_word,
    input logic [MergeMaxW-1:0] new_word,
    input logic [MergeMaxW-1:0] be,
    input int                   byte_w
  );
    logic [MergeMaxW-1:0] merged;
    logic [7:0]           lane;
    merged = old_word;
    for (int i = 0; i < MergeMaxW; i++) begin
      lane = 8'(i / byte_w);
      if (be[lane]) merged[i] = new_word[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dpram_init_ctrl.sv
// rtl/dpram_init_ctrl.sv - post-reset zero-fill sequencer for dpram_sc_init
module dpram_init_ctrl
  import dpram_pkg::*;
#(
  parameter int Depth       = 8,
  parameter bit InitOnReset = 1'b1,
  parameter int PtrWidth    = $clog2(Depth)
) (
  input  logic                clk_wr,
  input  logic                rst_sync_n,
  output logic                init_we,
  output logic [PtrWidth-1:0] init_addr,
  output logic                init_done
);

  localparam logic [PtrWidth-1:0] LastAddr   = PtrWidth'(Depth - 1);
  localparam dpram_state_e        ResetState = InitOnReset ? ST_INIT : ST_READY;

  dpram_state_e        state_q, state_d;
  logic [PtrWidth-1:0] init_cnt_q, init_cnt_d;
  logic                init_done_q;

  always_ff @(posedge clk_wr or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q     <= ResetState;
      init_cnt_q  <= '0;
      init_done_q <= !InitOnReset;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= (state_d == ST_READY);
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_we    = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        if (init_cnt_q == LastAddr) begin
          state_d = ST_READY;
        end else begin
          init_cnt_d = init_cnt_q + PtrWidth'(1);
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  assign init_addr = init_cnt_q;
  assign init_done = init_done_q;

endmodule

// File: rtl/dpram_sc_init.sv
// rtl/dpram_sc_init.sv - single-clock dual-port RAM with byte enables, 1/2-cycle reads and zero-fill init
module dpram_sc_init
  import dpram_pkg::*;
#(
  parameter int   Depth       = 8,
  parameter int   Width       = 32,
  parameter int   ByteW       = 8,
  parameter int   RdLatency   = 1,
  parameter bit   WriteFirst  = 1'b1,
  parameter bit   InitOnReset = 1'b1,
  localparam int  NBytes      = Width / ByteW,
  localparam int  PtrWidth    = $clog2(Depth)
) (
  input  logic                clk_wr,
  input  logic                rst_sync_n,
  input  logic                i_wr_en,
  input  logic                i_wr_full,
  input  logic [PtrWidth-1:0] i_wr_ptr,
  input  logic [NBytes-1:0]   i_wr_be,
  input  logic [Width-1:0]    i_wr_data,
  input  logic                i_rd_en,
  input  logic                i_rd_empty,
  input  logic [PtrWidth-1:0] i_rd_ptr,
  output logic [Width-1:0]    o_rd_data,
  output logic                o_rd_valid,
  output logic                o_init_done
);

  if (Width % ByteW != 0) begin : g_bad_width
    $error("dpram_sc_init: Width must be a multiple of ByteW");
  end
  if (Depth < 2) begin : g_bad_depth
    $error("dpram_sc_init: Depth must be at least 2");
  end
  if (RdLatency < RdLatencyMin || RdLatency > RdLatencyMax) begin : g_bad_latency
    $error("dpram_sc_init: RdLatency must be 1 or 2");
  end
  if (Width > MergeMaxW) begin : g_bad_merge
    $error("dpram_sc_init: Width exceeds the byte-merge helper");
  end

  logic [Width-1:0] mem [Depth];

  logic                init_we;
  logic [PtrWidth-1:0] init_addr;
  logic                init_done;

  dpram_init_ctrl #(
    .Depth       (Depth),
    .InitOnReset (InitOnReset),
    .PtrWidth    (PtrWidth)
  ) u_init_ctrl (
    .clk_wr     (clk_wr),
    .rst_sync_n (rst_sync_n),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_done  (init_done)
  );

  logic                wr_fire;
  logic                rd_fire;
  logic                same_addr;
  logic [Width-1:0]    wr_merged;
  logic [Width-1:0]    rd_word;
  logic                mem_we;
  logic [PtrWidth-1:0] mem_addr;
  logic [Width-1:0]    mem_wdata;

  assign wr_fire   = init_done & i_wr_en & ~i_wr_full;
  assign rd_fire   = init_done & i_rd_en & ~i_rd_empty;
  assign same_addr = wr_fire & rd_fire & (i_wr_ptr == i_rd_ptr);

  // The merged word doubles as the write-first bypass, so a colliding read sees exactly what lands in the array.
  assign wr_merged = Width'(be_merge(MergeMaxW'(mem[i_wr_ptr]), MergeMaxW'(i_wr_data),
                                     MergeMaxW'(i_wr_be), ByteW));

  always_comb begin
    mem_we    = wr_fire;
    mem_addr  = i_wr_ptr;
    mem_wdata = wr_merged;
    if (init_we) begin
      mem_we    = 1'b1;
      mem_addr  = init_addr;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk_wr) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign rd_word = (WriteFirst && same_addr) ? wr_merged : mem[i_rd_ptr];

  logic             s1_valid;
  logic [Width-1:0] s1_data;

  always_ff @(posedge clk_wr or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_data <= rd_word;
      end
    end
  end

  if (RdLatency == RdLatencyMin) begin : g_lat1
    assign o_rd_data  = s1_data;
    assign o_rd_valid = s1_valid;
  end else begin : g_lat2
    logic             s2_valid;
    logic [Width-1:0] s2_data;

    always_ff @(posedge clk_wr or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign o_rd_data  = s2_data;
    assign o_rd_valid = s2_valid;
  end

  assign o_init_done = init_done;

endmodule

// File: tb/tb_dpram_sc_init.sv
// tb/tb_dpram_sc_init.sv - scoreboard bench for dpram_sc_init at latency 1/write-first and latency 2/read-first
module tb_dpram_sc_init;

  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int NB    = 4;
  localparam int PW    = 3;

  logic          clk_wr = 1'b0;
  logic          rst_sync_n = 1'b0;
  logic          wr_en, wr_full, rd_en, rd_empty;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NB-1:0] wr_be;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  a_data, b_data;
  logic          a_valid, b_valid, a_done, b_done;

  typedef struct packed {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         q [2][$];
  logic [W-1:0] mon_d [2];
  logic         mon_v [2];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;

  always #5 clk_wr = ~clk_wr;
  always @(posedge clk_wr) cyc <= cyc + 1;

  dpram_sc_init #(
    .Depth(DEPTH), .Width(W), .ByteW(8), .RdLatency(1), .WriteFirst(1'b1), .InitOnReset(1'b1)
  ) dut_a (
    .clk_wr(clk_wr), .rst_sync_n(rst_sync_n),
    .i_wr_en(wr_en), .i_wr_full(wr_full), .i_wr_ptr(wr_ptr), .i_wr_be(wr_be), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_empty(rd_empty), .i_rd_ptr(rd_ptr),
    .o_rd_data(a_data), .o_rd_valid(a_valid), .o_init_done(a_done)
  );

  dpram_sc_init #(
    .Depth(DEPTH), .Width(W), .ByteW(8), .RdLatency(2), .WriteFirst(1'b0), .InitOnReset(1'b1)
  ) dut_b (
    .clk_wr(clk_wr), .rst_sync_n(rst_sync_n),
    .i_wr_en(wr_en), .i_wr_full(wr_full), .i_wr_ptr(wr_ptr), .i_wr_be(wr_be), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_empty(rd_empty), .i_rd_ptr(rd_ptr),
    .o_rd_data(b_data), .o_rd_valid(b_valid), .o_init_done(b_done)
  );

  assign mon_v[0] = a_valid;
  assign mon_v[1] = b_valid;
  assign mon_d[0] = a_data;
  assign mon_d[1] = b_data;

  if ((1 << PW) != DEPTH) begin : g_ptr_chk
    always @(negedge clk_wr) begin
      if (rst_sync_n && ((wr_en && 32'(wr_ptr) >= DEPTH) || (rd_en && 32'(rd_ptr) >= DEPTH))) begin
        total++;
        bad++;
        $display("FAIL ptr_range wr_ptr=%0d rd_ptr=%0d depth=%0d", wr_ptr, rd_ptr, DEPTH);
      end
    end
  end

  always @(negedge clk_wr) begin : monitor
    exp_t e;
    if (rst_sync_n) begin
      for (int p = 0; p < 2; p++) begin
        if (mon_v[p]) begin
          if (q[p].size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_valid port%0d cyc=%0d data=%h expected no read", p, cyc, mon_d[p]);
          end else begin
            e = q[p].pop_front();
            total++;
            if (mon_d[p] !== e.data) begin
              bad++;
              $display("FAIL rd_data port%0d cyc=%0d actual=%h expected=%h", p, cyc, mon_d[p], e.data);
            end
            total++;
            if (cyc != e.due) begin
              bad++;
              $display("FAIL rd_latency port%0d actual_cyc=%0d expected_cyc=%0d", p, cyc, e.due);
            end
          end
        end else if (q[p].size() != 0 && q[p][0].due < cyc) begin
          e = q[p].pop_front();
          total++;
          bad++;
          $display("FAIL missing_valid port%0d cyc=%0d expected data=%h due=%0d", p, cyc, e.data, e.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc_op(input logic we, input logic [PW-1:0] wp, input logic [NB-1:0] wbe,
                        input logic [W-1:0] wd, input logic wfull,
                        input logic re, input logic [PW-1:0] rp, input logic rempty,
                        input logic [W-1:0] exp_a, input logic [W-1:0] exp_b, input bit push);
    wr_en = we; wr_ptr = wp; wr_be = wbe; wr_data = wd; wr_full = wfull;
    rd_en = re; rd_ptr = rp; rd_empty = rempty;
    if (push) begin
      q[0].push_back('{data: exp_a, due: cyc + 1});
      q[1].push_back('{data: exp_b, due: cyc + 2});
    end
    @(posedge clk_wr); #1;
    wr_en = 1'b0; rd_en = 1'b0; wr_full = 1'b0; rd_empty = 1'b0;
  endtask

  task automatic wr(input logic [PW-1:0] p, input logic [NB-1:0] be, input logic [W-1:0] d);
    cyc_op(1'b1, p, be, d, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [PW-1:0] p, input logic [W-1:0] ea, input logic [W-1:0] eb);
    cyc_op(1'b0, '0, '0, '0, 1'b0, 1'b1, p, 1'b0, ea, eb, 1'b1);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_wr); #1;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stim
    int n;
    wr_en = 1'b0; wr_full = 1'b0; rd_en = 1'b0; rd_empty = 1'b0;
    wr_ptr = '0; rd_ptr = '0; wr_be = '0; wr_data = '0;

    #3;
    check("rst_valid_a", 32'(a_valid), 32'd0);
    check("rst_valid_b", 32'(b_valid), 32'd0);
    check("rst_data_a", a_data, 32'h0);
    check("rst_data_b", b_data, 32'h0);
    check("rst_done_a", 32'(a_done), 32'd0);
    check("rst_done_b", 32'(b_done), 32'd0);

    @(negedge clk_wr); #1 rst_sync_n = 1'b1;
    for (int e = 1; e <= DEPTH; e++) begin
      if (e == 2) begin
        wr_en = 1'b1; wr_ptr = 3'd3; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
        rd_en = 1'b1; rd_ptr = 3'd3;
      end
      @(posedge clk_wr); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      check($sformatf("init_done_a_edge%0d", e), 32'(a_done), (e == DEPTH) ? 32'd1 : 32'd0);
      check($sformatf("init_done_b_edge%0d", e), 32'(b_done), (e == DEPTH) ? 32'd1 : 32'd0);
    end

    for (int i = 0; i < DEPTH; i++) rd(PW'(i), 32'h0, 32'h0);

    wr(3'd5, 4'b1111, 32'h11223344);
    wr(3'd5, 4'b0101, 32'hAABBCCDD);
    rd(3'd5, 32'h11BB33DD, 32'h11BB33DD);

    cyc_op(1'b1, 3'd2, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b1, 3'd2, 1'b0, 32'hCAFEF00D, 32'h00000000, 1'b1);
    rd(3'd2, 32'hCAFEF00D, 32'hCAFEF00D);
    cyc_op(1'b1, 3'd2, 4'b0011, 32'h12345678, 1'b0, 1'b1, 3'd2, 1'b0, 32'hCAFE5678, 32'hCAFEF00D, 1'b1);
    rd(3'd2, 32'hCAFE5678, 32'hCAFE5678);

    for (int i = 0; i < DEPTH; i++) wr(PW'(i), 4'hF, 32'hA0000000 | 32'(i));
    for (int i = 0; i < DEPTH; i++) rd(PW'(i), 32'hA0000000 | 32'(i), 32'hA0000000 | 32'(i));

    cyc_op(1'b1, 3'd6, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    rd(3'd6, 32'hA0000006, 32'hA0000006);
    for (int i = 0; i < 3; i++) cyc_op(1'b0, '0, '0, '0, 1'b0, 1'b1, 3'd0, 1'b1, '0, '0, 1'b0);
    tick(1);
    check("hold_data_a", a_data, 32'hA0000006);
    check("hold_data_b", b_data, 32'hA0000006);

    wr(3'd7, 4'b0000, 32'h12345678);
    rd(3'd7, 32'hA0000007, 32'hA0000007);
    tick(3);

    rd(3'd1, 32'hA0000001, 32'hA0000001);
    rst_sync_n = 1'b0;
    q[0].delete();
    q[1].delete();
    #1;
    check("midrst_valid_a", 32'(a_valid), 32'd0);
    check("midrst_valid_b", 32'(b_valid), 32'd0);
    check("midrst_data_a", a_data, 32'h0);
    check("midrst_data_b", b_data, 32'h0);
    check("midrst_done_a", 32'(a_done), 32'd0);
    check("midrst_done_b", 32'(b_done), 32'd0);

    @(negedge clk_wr); #1 rst_sync_n = 1'b1;
    n = 0;
    while (!(a_done && b_done) && n < 40) begin
      @(posedge clk_wr); #1;
      n++;
    end
    check("reinit_done", {30'd0, a_done, b_done}, 32'd3);
    check("reinit_edges", 32'(n), 32'(DEPTH));

    for (int i = 0; i < DEPTH; i++) rd(PW'(i), 32'h0, 32'h0);
    tick(4);
    check("drain_q_a", 32'(q[0].size()), 32'd0);
    check("drain_q_b", 32'(q[1].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
